riu_iodelay_scan: RTL and testbench

Scan controller sitting directly upstream of the RIU IODELAY read stage. On a single start command it sweeps a configured register range across selected byte groups and nibbles. For each read it issues one trigger, holds the read target stable, catches the completion edge and captures the returned word. It emits each word as a tagged result on a valid/ready stream toward the register-bank/AXI capture logic, with timeout, configuration-error and completion reporting.

---
 rtl/riu_scan_pkg.sv | 55 +++++
 rtl/riu_iodelay_scan_if.sv | 38 +++
 rtl/riu_scan_index.sv | 47 ++++
 rtl/riu_iodelay_scan.sv | 181 ++++++++++++++++++
 tb/tb_riu_iodelay_scan.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riu_scan_pkg.sv
// Shared types and constants for the RIU IODELAY scan controller.
package riu_scan_pkg;

  localparam int ADDR_W   = 6;
  localparam int BG_W     = 2;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 9;
  localparam int READ_LAT = 5;

  localparam int TAG_ADDR_LSB = 0;
  localparam int TAG_NIB_BIT  = 6;
  localparam int TAG_BG_LSB   = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_PUSH      = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_CFG     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  typedef struct packed {
    logic [BG_W-1:0]   bg;
    logic              nib;
    logic [ADDR_W-1:0] addr;
  } scan_idx_t;

  function automatic logic [BG_W-1:0] lowest_bg(input logic [3:0] m);
    logic [BG_W-1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = BG_W'(i);
    end
    return r;
  endfunction

  function automatic logic lowest_nib(input logic [1:0] m);
    return ~m[0];
  endfunction

  function automatic logic [TAG_W-1:0] make_tag(input scan_idx_t idx);
    logic [TAG_W-1:0] t;
    t = '0;
    t[TAG_ADDR_LSB +: ADDR_W] = idx.addr;
    t[TAG_NIB_BIT]            = idx.nib;
    t[TAG_BG_LSB +: BG_W]     = idx.bg;
    return t;
  endfunction

endpackage

// File: rtl/riu_iodelay_scan_if.sv
// Command, read-stage and result-stream signals of the scan controller.
interface riu_iodelay_scan_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic [5:0]       cfg_addr_first;
  logic [5:0]       cfg_addr_last;
  logic [3:0]       cfg_bg_mask;
  logic [1:0]       cfg_nib_mask;
  logic             riu_trig;
  logic [5:0]       riu_addr;
  logic             riu_nib;
  logic [1:0]       riu_bg;
  logic [15:0]      riu_rd_data;
  logic             riu_rd_done;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [8:0]       res_tag;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic [CNT_W-1:0] rd_count;

  modport slave (
    input  start, cfg_addr_first, cfg_addr_last, cfg_bg_mask, cfg_nib_mask,
    input  riu_rd_data, riu_rd_done, res_ready,
    output riu_trig, riu_addr, riu_nib, riu_bg,
    output res_valid, res_data, res_tag, busy, done, err, rd_count
  );

  modport master (
    output start, cfg_addr_first, cfg_addr_last, cfg_bg_mask, cfg_nib_mask,
    output riu_rd_data, riu_rd_done, res_ready,
    input  riu_trig, riu_addr, riu_nib, riu_bg,
    input  res_valid, res_data, res_tag, busy, done, err, rd_count
  );
endinterface

// File: rtl/riu_scan_index.sv
// Sweep-index stepper: addr innermost, then nibble, then byte group, skipping
// cleared mask bits. Purely combinational.
module riu_scan_index
  import riu_scan_pkg::*;
(
  input  logic [3:0]        i_bg_mask,
  input  logic [1:0]        i_nib_mask,
  input  logic [ADDR_W-1:0] i_addr_first,
  input  logic [ADDR_W-1:0] i_addr_last,
  input  scan_idx_t         i_cur,
  output scan_idx_t         o_next,
  output logic              o_is_last
);

  logic            w_bg_found;
  logic [BG_W-1:0] w_bg_next;

  always_comb begin
    w_bg_found = 1'b0;
    w_bg_next  = i_cur.bg;
    for (int i = 0; i < 4; i++) begin
      if (!w_bg_found && (i > int'(i_cur.bg)) && i_bg_mask[i]) begin
        w_bg_found = 1'b1;
        w_bg_next  = BG_W'(i);
      end
    end
  end

  // Addr never increments past last, so a range ending at 63 cannot wrap.
  always_comb begin
    o_next    = i_cur;
    o_is_last = 1'b0;
    if (i_cur.addr != i_addr_last) begin
      o_next.addr = i_cur.addr + ADDR_W'(1);
    end else if (!i_cur.nib && i_nib_mask[1]) begin
      o_next.nib  = 1'b1;
      o_next.addr = i_addr_first;
    end else if (w_bg_found) begin
      o_next.bg   = w_bg_next;
      o_next.nib  = lowest_nib(i_nib_mask);
      o_next.addr = i_addr_first;
    end else begin
      o_is_last = 1'b1;
    end
  end

endmodule

// File: rtl/riu_iodelay_scan.sv
// Scan controller upstream of the RIU IODELAY read stage: one trigger per read,
// edge-detected completion, tagged results on a valid/ready stream.
module riu_iodelay_scan
  import riu_scan_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 10
) (
  input logic               clk,
  input logic               rst,
  riu_iodelay_scan_if.slave bus
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_bg_mask;
  logic [1:0]          r_nib_mask;
  logic [ADDR_W-1:0]   r_first;
  logic [ADDR_W-1:0]   r_last;
  scan_idx_t           r_idx;
  logic                r_rd_done_q;
  logic [TMO_W-1:0]    r_tmo;
  logic [DATA_W-1:0]   r_res_data;
  logic [TAG_W-1:0]    r_res_tag;
  logic                r_done;
  logic                r_busy;
  err_t                r_err;
  logic [CNT_W-1:0]    r_rd_count;

  logic                w_cfg_bad;
  logic                w_start_acc;
  logic                w_start_ok;
  logic                w_cfg_err;
  logic                w_edge;
  logic                w_capture;
  logic                w_timeout;
  logic                w_accept;
  logic                w_finish;
  logic                w_load_next;
  logic                w_is_last;
  scan_idx_t           w_first_idx;
  scan_idx_t           w_next_idx;

  assign w_cfg_bad   = (bus.cfg_bg_mask == 4'd0) || (bus.cfg_nib_mask == 2'd0) ||
                       (bus.cfg_addr_first > bus.cfg_addr_last);
  assign w_start_acc = (r_state == ST_IDLE) && bus.start;
  assign w_start_ok  = w_start_acc && !w_cfg_bad;
  assign w_cfg_err   = w_start_acc && w_cfg_bad;
  // A done level already high at trigger never looks like an edge.
  assign w_edge      = bus.riu_rd_done && !r_rd_done_q;

  assign w_first_idx = '{bg:   lowest_bg(bus.cfg_bg_mask),
                         nib:  lowest_nib(bus.cfg_nib_mask),
                         addr: bus.cfg_addr_first};

  riu_scan_index u_index (
    .i_bg_mask    (r_bg_mask),
    .i_nib_mask   (r_nib_mask),
    .i_addr_first (r_first),
    .i_addr_last  (r_last),
    .i_cur        (r_idx),
    .o_next       (w_next_idx),
    .o_is_last    (w_is_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_load_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_edge) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PUSH;
        end else if (r_tmo == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PUSH: begin
        if (bus.res_ready) begin
          w_accept = 1'b1;
          if (w_is_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_load_next = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Timeout counter runs from the trigger cycle, so expiry lands at trigger+N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bg_mask   <= '0;
      r_nib_mask  <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_idx       <= '0;
      r_rd_done_q <= 1'b0;
      r_tmo       <= '0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= ERR_OK;
      r_rd_count  <= '0;
    end else begin
      r_rd_done_q <= bus.riu_rd_done;
      r_done      <= w_cfg_err || w_timeout || w_finish;

      if (w_start_acc) begin
        r_bg_mask  <= bus.cfg_bg_mask;
        r_nib_mask <= bus.cfg_nib_mask;
        r_first    <= bus.cfg_addr_first;
        r_last     <= bus.cfg_addr_last;
        r_err      <= w_cfg_bad ? ERR_CFG : ERR_OK;
        r_rd_count <= '0;
      end

      if (w_start_ok) begin
        r_idx  <= w_first_idx;
        r_busy <= 1'b1;
      end else if (w_load_next) begin
        r_idx <= w_next_idx;
      end

      if (w_start_ok || w_load_next) begin
        r_tmo <= '0;
      end else if (r_state == ST_ISSUE || r_state == ST_WAIT_DONE) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      if (w_capture) begin
        r_res_data <= bus.riu_rd_data;
        r_res_tag  <= make_tag(r_idx);
      end

      if (w_timeout) r_err <= ERR_TIMEOUT;
      if (w_timeout || w_finish) r_busy <= 1'b0;

      if (w_accept && (r_rd_count != '1)) begin
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
    end
  end

  assign bus.riu_trig  = (r_state == ST_ISSUE);
  assign bus.riu_addr  = r_idx.addr;
  assign bus.riu_nib   = r_idx.nib;
  assign bus.riu_bg    = r_idx.bg;
  assign bus.res_valid = (r_state == ST_PUSH);
  assign bus.res_data  = r_res_data;
  assign bus.res_tag   = r_res_tag;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rd_count  = r_rd_count;

endmodule

// File: tb/tb_riu_iodelay_scan.sv
// Scoreboard bench for riu_iodelay_scan with a behavioural read-stage model.
module tb_riu_iodelay_scan;

  localparam int TMO   = 64;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riu_iodelay_scan_if #(.CNT_W(CNT_W)) bus ();

  riu_iodelay_scan #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [8:0]  tag;
    logic [15:0] data;
  } res_t;

  res_t exp_q[$];
  res_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   trig_cnt = 0, done_cnt = 0, done_cyc = 0, hs_scan = 0;
  int   trig_q[$];
  int   vld_q[$];

  logic        stuck = 1'b0;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'h0;
  logic [15:0] salt = 16'h0;
  int          ready_mode = 0;
  int          stall_left = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_word(input logic [8:0] tag, input logic [15:0] s);
    return (16'(tag) * 16'd40503) ^ s;
  endfunction

  // Read stage: samples addr at trigger, nibble two cycles later, bg at completion.
  logic [5:0] m_a;
  logic       m_n;
  logic [1:0] m_b;
  initial begin
    bus.riu_rd_done = 1'b0;
    bus.riu_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (stuck) begin
        bus.riu_rd_done = 1'b1;
      end else if (!rst && bus.riu_trig) begin
        m_a = bus.riu_addr;
        @(posedge clk); #1 bus.riu_rd_done = 1'b0;
        @(posedge clk); #1 m_n = bus.riu_nib;
        repeat (3) @(posedge clk);
        #1 m_b = bus.riu_bg;
        bus.riu_rd_data = ovr_en ? ovr_val : rd_word({m_b, m_n, m_a}, salt);
        bus.riu_rd_done = 1'b1;
      end
    end
  end

  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        1: bus.res_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (bus.res_valid && hs_scan == 1 && stall_left > 0) begin
            bus.res_ready = 1'b0;
            stall_left--;
          end else begin
            bus.res_ready = 1'b1;
          end
        end
        default: bus.res_ready = 1'b1;
      endcase
    end
  end

  // Monitor: event log, hold checks under backpressure, scoreboard pop.
  logic        prev_pend = 1'b0, prev_valid = 1'b0;
  logic [15:0] prev_data;
  logic [8:0]  prev_tag;
  always @(negedge clk) begin
    if (rst) begin
      prev_pend  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.riu_trig) begin trig_cnt++; trig_q.push_back(cyc); end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.res_valid && !prev_valid) vld_q.push_back(cyc);
      if (prev_pend) begin
        chk("hold_valid", 32'(bus.res_valid), 32'd1);
        chk("hold_data", 32'(bus.res_data), 32'(prev_data));
        chk("hold_tag", 32'(bus.res_tag), 32'(prev_tag));
        chk("trig_while_pending", 32'(bus.riu_trig), 32'd0);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got tag %0h data %0h, expected no result", bus.res_tag, bus.res_data);
        end else begin
          e = exp_q.pop_front();
          chk("res_tag", 32'(bus.res_tag), 32'(e.tag));
          chk("res_data", 32'(bus.res_data), 32'(e.data));
        end
        hs_scan++;
      end
      prev_pend  = bus.res_valid && !bus.res_ready;
      prev_valid = bus.res_valid;
      prev_data  = bus.res_data;
      prev_tag   = bus.res_tag;
    end
  end

  task automatic pulse_start(input logic [5:0] f, input logic [5:0] l, input logic [3:0] bm,
                             input logic [1:0] nm, output int sc);
    @(negedge clk);
    bus.cfg_addr_first = f;
    bus.cfg_addr_last  = l;
    bus.cfg_bg_mask    = bm;
    bus.cfg_nib_mask   = nm;
    bus.start          = 1'b1;
    sc                 = cyc;
    @(negedge clk);
    bus.start          = 1'b0;
    bus.cfg_addr_first = 6'($urandom);
    bus.cfg_addr_last  = 6'($urandom);
    bus.cfg_bg_mask    = 4'($urandom);
    bus.cfg_nib_mask   = 2'($urandom);
  endtask

  // Reference sweep: plain nested loops over the enabled groups/nibbles/addresses.
  task automatic push_exp(input logic [5:0] f, input logic [5:0] l, input logic [3:0] bm,
                          input logic [1:0] nm, output int n, output logic bad);
    logic [8:0] t;
    n   = 0;
    bad = (bm == 4'd0) || (nm == 2'd0) || (f > l);
    if (!bad) begin
      for (int b = 0; b < 4; b++) begin
        if (!bm[b]) continue;
        for (int k = 0; k < 2; k++) begin
          if (!nm[k]) continue;
          for (int a = int'(f); a <= int'(l); a++) begin
            t = {2'(b), 1'(k), 6'(a)};
            exp_q.push_back('{tag: t, data: (ovr_en ? ovr_val : rd_word(t, salt))});
            n++;
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: got no done pulse within %0d cycles, expected one", budget);
    end
  endtask

  task automatic run_scan(input logic [5:0] f, input logic [5:0] l, input logic [3:0] bm,
                          input logic [1:0] nm, input bit mid);
    int   n, d0, t0, sc, sc2;
    logic bad;
    exp_q.delete();
    push_exp(f, l, bm, nm, n, bad);
    hs_scan = 0;
    d0      = done_cnt;
    t0      = trig_cnt;
    trig_q.delete();
    vld_q.delete();
    pulse_start(f, l, bm, nm, sc);
    if (mid && n >= 2) begin
      repeat (8) @(negedge clk);
      pulse_start(6'($urandom), 6'($urandom), 4'($urandom), 2'($urandom), sc2);
    end
    wait_done(d0, 40 * n + 100);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("err", 32'(bus.err), bad ? 32'd1 : 32'd0);
    chk("rd_count", 32'(bus.rd_count), 32'(n));
    chk("results_seen", 32'(hs_scan), 32'(n));
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    if (bad) begin
      chk("cfg_done_cycle", 32'(done_cyc - sc), 32'd1);
      chk("cfg_no_trig", 32'(trig_cnt - t0), 32'd0);
    end else begin
      chk("trig_count", 32'(trig_cnt - t0), 32'(n));
    end
    exp_q.delete();
  endtask

  initial begin : main
    int sc, d0, t0, k, n;
    logic bad;
    logic [5:0] rf, rl;
    bus.start          = 1'b0;
    bus.cfg_addr_first = 6'd0;
    bus.cfg_addr_last  = 6'd0;
    bus.cfg_bg_mask    = 4'd0;
    bus.cfg_nib_mask   = 2'd0;

    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(bus.riu_trig), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
    chk("rst_tag", 32'(bus.res_tag), 32'd0);
    chk("rst_addr", 32'(bus.riu_addr), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic sweep across bg0/bg2, both nibbles, addr 2..3.
    salt = 16'($urandom);
    run_scan(6'd2, 6'd3, 4'b0101, 2'b11, 1'b0);
    chk("sweep_trig_q", 32'(trig_q.size()), 32'd8);
    for (int i = 1; i < trig_q.size(); i++) chk("read_period", 32'(trig_q[i] - trig_q[i-1]), 32'd7);
    if (vld_q.size() == 8) chk("done_after_last_hs", 32'(done_cyc - vld_q[7]), 32'd1);
    else chk("sweep_vld_q", 32'(vld_q.size()), 32'd8);

    // Single read at the top corner.
    ovr_en  = 1'b1;
    ovr_val = 16'hBEEF;
    run_scan(6'd63, 6'd63, 4'b1000, 2'b10, 1'b0);
    if (trig_q.size() >= 1 && vld_q.size() >= 1)
      chk("first_valid_latency", 32'(vld_q[0] - trig_q[0]), 32'd6);
    else chk("single_vld_q", 32'(vld_q.size()), 32'd1);
    chk("no_wrap_addr", 32'(bus.riu_addr), 32'd63);
    ovr_en = 1'b0;

    // Backpressure on the 2nd result for 10 cycles.
    salt       = 16'($urandom);
    ready_mode = 2;
    stall_left = 10;
    run_scan(6'd0, 6'd3, 4'b0001, 2'b01, 1'b0);
    if (trig_q.size() >= 3) begin
      chk("bp_gap_1_2", 32'(trig_q[1] - trig_q[0]), 32'd7);
      chk("bp_gap_2_3", 32'(trig_q[2] - trig_q[1]), 32'd17);
    end else chk("bp_trig_q", 32'(trig_q.size()), 32'd4);
    ready_mode = 0;

    // Done level stuck high: completion never seen, timeout.
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    hs_scan = 0;
    d0      = done_cnt;
    t0      = trig_cnt;
    trig_q.delete();
    pulse_start(6'd0, 6'd0, 4'b0001, 2'b01, sc);
    wait_done(d0, 200);
    repeat (3) @(negedge clk);
    chk("tmo_trig_count", 32'(trig_cnt - t0), 32'd1);
    if (trig_q.size() >= 1) chk("tmo_done_cycle", 32'(done_cyc - trig_q[0]), 32'd64);
    chk("tmo_err", 32'(bus.err), 32'd2);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_results", 32'(hs_scan), 32'd0);
    chk("tmo_rd_count", 32'(bus.rd_count), 32'd0);
    stuck = 1'b0;

    // Configuration errors, then a scan with a mid-scan start pulse.
    run_scan(6'd5, 6'd4, 4'b0101, 2'b11, 1'b0);
    run_scan(6'd0, 6'd3, 4'b0000, 2'b01, 1'b0);
    run_scan(6'd0, 6'd3, 4'b0001, 2'b00, 1'b0);
    salt = 16'($urandom);
    run_scan(6'd10, 6'd12, 4'b0110, 2'b11, 1'b1);

    // Asynchronous reset while waiting for the second completion.
    salt = 16'($urandom);
    exp_q.delete();
    push_exp(6'd0, 6'd3, 4'b0001, 2'b01, n, bad);
    t0 = trig_cnt;
    pulse_start(6'd0, 6'd3, 4'b0001, 2'b01, sc);
    k = 0;
    while (trig_cnt < t0 + 2 && k < 100) begin @(negedge clk); k++; end
    chk("rst_test_trigs", 32'(trig_cnt - t0), 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_trig", 32'(bus.riu_trig), 32'd0);
    chk("arst_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    chk("arst_rd_count", 32'(bus.rd_count), 32'd0);
    chk("arst_addr", 32'(bus.riu_addr), 32'd0);
    chk("arst_data", 32'(bus.res_data), 32'd0);
    chk("arst_tag", 32'(bus.res_tag), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    salt = 16'($urandom);
    run_scan(6'd0, 6'd3, 4'b0001, 2'b01, 1'b0);

    // Randomised scans with random backpressure.
    ready_mode = 1;
    for (int it = 0; it < 10; it++) begin
      rf = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) rl = (int'(rf) + 3 > 63) ? 6'd63 : rf + 6'($urandom_range(0, 3));
      else rl = 6'($urandom_range(0, 63));
      salt = 16'($urandom);
      run_scan(rf, rl, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
